// File: rtl/step_decoder.sv
// Stepper-motor phase decoder.
// Watches the phase drive pattern applied to a 4-phase stepper and tracks
// the shaft position. Legal forward/reverse phase transitions adjust pos.
// An opposite-phase jump or a multi-hot drive code latches a sticky fault.
// A stall flag rises when no step has been counted for STALL_CYC cycles.
module step_decoder #(
  parameter int POS_W     = 8,
  parameter int STALL_CYC = 16
) (
  input  logic             drv_clk,
  input  logic             reset,
  input  logic [3:0]       phase_in,
  input  logic             clr_pos,
  input  logic [POS_W-1:0] target,
  output logic [POS_W-1:0] pos,
  output logic             dir,
  output logic             step,
  output logic             err,
  output logic             stalled,
  output logic             at_target
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  // STALL_CYC is limited to 2..255, so an 8-bit counter always suffices.
  localparam logic [7:0] STALL_MAX = 8'(STALL_CYC);

  state_t     state;
  logic [3:0] last_ph;
  logic [7:0] stall_cnt;

  logic       ph_zero;
  logic       ph_onehot;
  logic       ph_multi;
  logic [3:0] fwd_ph;
  logic [3:0] rev_ph;
  logic       is_fwd;
  logic       is_rev;
  logic       is_hold;

  // Classify the incoming phase relative to the last legal phase.
  // Forward order A->B->C->D->A is a left rotate of the one-hot code;
  // reverse order is a right rotate; the opposite phase is a rotate by two.
  assign ph_zero   = (phase_in == 4'b0000);
  assign ph_onehot = $onehot(phase_in);
  assign ph_multi  = !ph_zero && !ph_onehot;
  assign fwd_ph    = {last_ph[2:0], last_ph[3]};
  assign rev_ph    = {last_ph[0], last_ph[3:1]};
  assign is_fwd    = ph_onehot && (phase_in == fwd_ph);
  assign is_rev    = ph_onehot && (phase_in == rev_ph);
  assign is_hold   = ph_zero || (phase_in == last_ph);

  // Status outputs derived straight from registered state.
  assign stalled   = (state == TRACK) && (stall_cnt == STALL_MAX);
  assign at_target = (pos == target);

  // Decoder FSM: reset beats clear, clear beats any step on the same edge.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values; blocking would create ordering races.
  always_ff @(posedge drv_clk) begin
    if (reset) begin
      state     <= IDLE;
      last_ph   <= 4'b0000;
      pos       <= '0;
      dir       <= 1'b0;
      step      <= 1'b0;
      err       <= 1'b0;
      stall_cnt <= 8'd0;
    end else if (clr_pos) begin
      state     <= IDLE;
      last_ph   <= 4'b0000;
      pos       <= '0;
      step      <= 1'b0;
      err       <= 1'b0;
      stall_cnt <= 8'd0;
    end else begin
      step <= 1'b0;
      case (state)
        IDLE: begin
          stall_cnt <= 8'd0;
          if (ph_multi) begin
            err   <= 1'b1;
            state <= FAULT;
          end else if (ph_onehot) begin
            last_ph <= phase_in;
            state   <= TRACK;
          end
        end
        TRACK: begin
          if (is_fwd) begin
            pos       <= pos + POS_W'(1);
            dir       <= 1'b1;
            step      <= 1'b1;
            last_ph   <= phase_in;
            stall_cnt <= 8'd0;
          end else if (is_rev) begin
            pos       <= pos - POS_W'(1);
            dir       <= 1'b0;
            step      <= 1'b1;
            last_ph   <= phase_in;
            stall_cnt <= 8'd0;
          end else if (is_hold) begin
            if (stall_cnt != STALL_MAX) begin
              stall_cnt <= stall_cnt + 8'd1;
            end
          end else begin
            // Opposite-phase jump or multi-hot drive: lost synchronisation.
            err       <= 1'b1;
            stall_cnt <= 8'd0;
            state     <= FAULT;
          end
        end
        FAULT: begin
          stall_cnt <= 8'd0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
